// File: rtl/accel_pkg.sv
// ---------------------------------------------------------------------------
// accel_pkg
// Shared definitions for the accelerometer sample path: the stored sample
// record, default widths and depth, and a small saturating-counter helper.
// No ports (package).
// ---------------------------------------------------------------------------
package accel_pkg;

  // Default axis word width and FIFO depth used across the accelerometer path
  localparam int ACCEL_DATA_W     = 16;
  localparam int ACCEL_FIFO_DEPTH = 16;

  // Width of the capture sequence number and of the drop statistics counter
  localparam int ACCEL_SEQ_W  = 8;
  localparam int ACCEL_DROP_W = 8;

  // One captured sample as it sits in the FIFO
  typedef struct packed {
    logic [ACCEL_DATA_W-1:0] x;
    logic [ACCEL_DATA_W-1:0] y;
    logic [ACCEL_DATA_W-1:0] z;
    logic [ACCEL_SEQ_W-1:0]  seq;
  } accel_sample_t;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [ACCEL_DROP_W-1:0] sat_inc_drop(
    input logic [ACCEL_DROP_W-1:0] value
  );
    if (value == {ACCEL_DROP_W{1'b1}}) begin
      return value;
    end
    return value + ACCEL_DROP_W'(1);
  endfunction

endpackage

// File: rtl/accel_fifo_mem.sv
// ---------------------------------------------------------------------------
// accel_fifo_mem
// Sample storage for the accelerometer FIFO: one synchronous write port and
// one combinational (asynchronous) read port. Contents are never reset, so
// the array maps onto plain registers or distributed/MLAB memory.
//
// Ports
//   clk      in   clock
//   wr_en    in   write strobe, stores wr_data at wr_addr on the rising edge
//   wr_addr  in   ADDR_W  write address
//   wr_data  in   WIDTH   packed sample record to store
//   rd_addr  in   ADDR_W  read address
//   rd_data  out  WIDTH   record at rd_addr, available in the same cycle
// ---------------------------------------------------------------------------
module accel_fifo_mem
  import accel_pkg::*;
#(
  parameter int WIDTH  = 3 * ACCEL_DATA_W + ACCEL_SEQ_W,
  parameter int DEPTH  = ACCEL_FIFO_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Single write port. No reset on purpose: keeping the array reset-free is
  // what lets synthesis pack it into distributed memory.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Combinational read so the head entry can fall through to the outputs
  // without a read-latency cycle.
  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/accel_sample_fifo.sv
// ---------------------------------------------------------------------------
// accel_sample_fifo
// First-word-fall-through FIFO that captures filtered accelerometer samples.
// A sample is pushed once per rising edge of sample_valid and tagged with an
// 8-bit capture sequence number. When the FIFO is full the new sample is
// dropped and recorded in a sticky overflow flag and a saturating counter.
//
// Ports
//   clk            in   system clock
//   rst            in   synchronous active-high reset
//   sample_valid   in   new-sample strobe (may be several cycles wide)
//   x_in/y_in/z_in in   DATA_W axis data, stable while sample_valid is high
//   rd_pop         in   consume the head entry
//   clr_ovf        in   clear overflow and drop_cnt
//   rd_valid       out  FIFO non-empty, head data valid
//   rd_x/rd_y/rd_z out  DATA_W head axis data (0 while empty)
//   rd_seq         out  8-bit head sequence number (0 while empty)
//   count          out  occupancy, $clog2(DEPTH)+1 bits
//   overflow       out  sticky: a sample has been dropped
//   drop_cnt       out  dropped-sample count, saturates at 255
// ---------------------------------------------------------------------------
module accel_sample_fifo
  import accel_pkg::*;
#(
  parameter int DEPTH  = ACCEL_FIFO_DEPTH,
  parameter int DATA_W = ACCEL_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sample_valid,
  input  logic [DATA_W-1:0]        x_in,
  input  logic [DATA_W-1:0]        y_in,
  input  logic [DATA_W-1:0]        z_in,
  input  logic                     rd_pop,
  input  logic                     clr_ovf,
  output logic                     rd_valid,
  output logic [DATA_W-1:0]        rd_x,
  output logic [DATA_W-1:0]        rd_y,
  output logic [DATA_W-1:0]        rd_z,
  output logic [ACCEL_SEQ_W-1:0]   rd_seq,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [ACCEL_DROP_W-1:0]  drop_cnt
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = 3 * DATA_W + ACCEL_SEQ_W;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  // Strobe edge detection
  logic sv_prev;
  logic armed;
  logic push_req;

  // Pointer / occupancy state
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic [ACCEL_SEQ_W-1:0] seq_q;

  // Statistics
  logic overflow_q;
  logic [ACCEL_DROP_W-1:0] drop_q;

  // Per-cycle decisions
  logic is_empty;
  logic is_full;
  logic do_pop;
  logic do_write;
  logic do_drop;

  // Storage interface
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] head_entry;

  // A push is a rising edge of sample_valid. The armed bit covers the reset
  // release case: a strobe that was already high while rst was asserted is
  // not a new sample, so we wait for it to drop before accepting edges again.
  assign push_req = sample_valid & ~sv_prev & armed;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == FULL_COUNT);

  // A pop on an empty FIFO is ignored. Because do_pop only exists when there
  // is an entry, push+pop while full frees the slot the push then reuses.
  assign do_pop   = rd_pop & ~is_empty;
  assign do_write = push_req & (~is_full | do_pop);
  assign do_drop  = push_req & is_full & ~do_pop;

  assign wr_entry = {x_in, y_in, z_in, seq_q};

  accel_fifo_mem #(
    .WIDTH  (ENTRY_W),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (do_write),
    .wr_addr (wr_ptr),
    .wr_data (wr_entry),
    .rd_addr (rd_ptr),
    .rd_data (head_entry)
  );

  // Edge-detection history. During reset the history is cleared, and armed
  // captures whether the strobe is currently low, which is what decides if
  // the first high level after release may count as a rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sv_prev <= 1'b0;
      armed   <= ~sample_valid;
    end else begin
      sv_prev <= sample_valid;
      if (!sample_valid) begin
        armed <= 1'b1;
      end
    end
  end

  // Read/write pointers and occupancy. Pointers are log2(DEPTH) wide so they
  // wrap naturally; count carries the extra bit that tells full from empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_write) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_write, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Capture sequence number advances on every push attempt, including the
  // ones that get dropped, so gaps in rd_seq reveal lost samples downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      seq_q <= '0;
    end else if (push_req) begin
      seq_q <= seq_q + ACCEL_SEQ_W'(1);
    end
  end

  // Overflow statistics. A clear in the same cycle as a drop takes priority,
  // so that drop never shows up in the counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else if (clr_ovf) begin
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else if (do_drop) begin
      overflow_q <= 1'b1;
      drop_q     <= sat_inc_drop(drop_q);
    end
  end

  // Head data falls straight through from storage. While empty the outputs
  // are forced to zero, which also hides the unreset storage contents.
  always_comb begin
    rd_valid = ~is_empty;
    rd_x     = '0;
    rd_y     = '0;
    rd_z     = '0;
    rd_seq   = '0;
    if (!is_empty) begin
      rd_x   = head_entry[ENTRY_W-1 -: DATA_W];
      rd_y   = head_entry[ENTRY_W-1-DATA_W -: DATA_W];
      rd_z   = head_entry[ENTRY_W-1-2*DATA_W -: DATA_W];
      rd_seq = head_entry[ACCEL_SEQ_W-1:0];
    end
  end

  assign count    = count_q;
  assign overflow = overflow_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_accel_sample_fifo.sv
// ---------------------------------------------------------------------------
// tb_accel_sample_fifo
// Self-checking bench for accel_sample_fifo: directed scenarios followed by
// randomized strobes/pops/clears, compared each cycle against a queue model.
// ---------------------------------------------------------------------------
module tb_accel_sample_fifo;
  import accel_pkg::*;

  localparam int DEPTH  = ACCEL_FIFO_DEPTH;
  localparam int DATA_W = ACCEL_DATA_W;

  logic clk;
  logic rst;
  logic sample_valid;
  logic [DATA_W-1:0] x_in, y_in, z_in;
  logic rd_pop;
  logic clr_ovf;
  logic rd_valid;
  logic [DATA_W-1:0] rd_x, rd_y, rd_z;
  logic [7:0] rd_seq;
  logic [$clog2(DEPTH):0] count;
  logic overflow;
  logic [7:0] drop_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state
  accel_sample_t model_q[$];
  logic          m_last_sv;
  logic [7:0]    m_seq;
  logic          m_ovf;
  int            m_drops;

  accel_sample_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .x_in         (x_in),
    .y_in         (y_in),
    .z_in         (z_in),
    .rd_pop       (rd_pop),
    .clr_ovf      (clr_ovf),
    .rd_valid     (rd_valid),
    .rd_x         (rd_x),
    .rd_y         (rd_y),
    .rd_z         (rd_z),
    .rd_seq       (rd_seq),
    .count        (count),
    .overflow     (overflow),
    .drop_cnt     (drop_cnt)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Guard against a hung run
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Compare every DUT output with the model
  task automatic checkAll();
    accel_sample_t head;
    head = '0;
    if (model_q.size() > 0) head = model_q[0];
    checkOutput("count",    32'(count),    32'(model_q.size()));
    checkOutput("rd_valid", 32'(rd_valid), 32'(model_q.size() > 0));
    checkOutput("rd_x",     32'(rd_x),     32'(head.x));
    checkOutput("rd_y",     32'(rd_y),     32'(head.y));
    checkOutput("rd_z",     32'(rd_z),     32'(head.z));
    checkOutput("rd_seq",   32'(rd_seq),   32'(head.seq));
    checkOutput("overflow", 32'(overflow), 32'(m_ovf));
    checkOutput("drop_cnt", 32'(drop_cnt), 32'(m_drops));
  endtask

  // Drive one cycle of inputs (called at a falling edge), advance the model
  // by the FIFO rules, then sample at the next falling edge.
  task automatic applyStimulus(input logic sv, input logic pop, input logic clr,
                               input logic [DATA_W-1:0] x,
                               input logic [DATA_W-1:0] y,
                               input logic [DATA_W-1:0] z);
    accel_sample_t e;
    logic is_push;
    sample_valid = sv;
    rd_pop       = pop;
    clr_ovf      = clr;
    x_in         = x;
    y_in         = y;
    z_in         = z;
    is_push   = sv && !m_last_sv;
    m_last_sv = sv;
    if (pop && model_q.size() > 0) void'(model_q.pop_front());
    if (is_push) begin
      if (model_q.size() < DEPTH) begin
        e.x = x; e.y = y; e.z = z; e.seq = m_seq;
        model_q.push_back(e);
      end else begin
        m_ovf = 1'b1;
        if (m_drops < 255) m_drops++;
      end
      m_seq = m_seq + 8'd1;
    end
    if (clr) begin
      m_ovf   = 1'b0;
      m_drops = 0;
    end
    @(posedge clk);
    @(negedge clk);
    checkAll();
  endtask

  // Hold rst for one cycle with the given strobe level
  task automatic doReset(input logic sv);
    rst          = 1'b1;
    sample_valid = sv;
    rd_pop       = 1'b0;
    clr_ovf      = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_q.delete();
    m_seq     = 8'd0;
    m_ovf     = 1'b0;
    m_drops   = 0;
    m_last_sv = sv;
    checkAll();
  endtask

  // One strobe of the given width followed by a low cycle
  task automatic strobe(input logic [DATA_W-1:0] x, input int width);
    for (int w = 0; w < width; w++) applyStimulus(1'b1, 1'b0, 1'b0, x, ~x, x ^ 16'h5A5A);
    applyStimulus(1'b0, 1'b0, 1'b0, x, ~x, x ^ 16'h5A5A);
  endtask

  task automatic popOnce();
    applyStimulus(1'b0, 1'b1, 1'b0, '0, '0, '0);
  endtask

  initial begin
    logic [DATA_W-1:0] cx, cy, cz;
    logic sv, pop, clr, drv_last;
    rst = 1'b0; sample_valid = 1'b0; rd_pop = 1'b0; clr_ovf = 1'b0;
    x_in = '0; y_in = '0; z_in = '0;
    m_last_sv = 1'b0; m_seq = 8'd0; m_ovf = 1'b0; m_drops = 0;
    @(negedge clk);

    // Three wide strobes, then drain in order
    $display("[TB] wide strobes");
    doReset(1'b0);
    for (int i = 0; i < 3; i++) strobe(16'(16 * (i + 1)), 5);
    checkOutput("t1_count", 32'(count), 32'd3);
    for (int i = 0; i < 3; i++) begin
      checkOutput("t1_x",   32'(rd_x),   32'(16 * (i + 1)));
      checkOutput("t1_seq", 32'(rd_seq), 32'(i));
      popOnce();
    end
    checkOutput("t1_valid", 32'(rd_valid), 32'd0);

    // Overflow: 18 pushes into 16 slots
    $display("[TB] overflow");
    doReset(1'b0);
    for (int i = 0; i < 18; i++) strobe(16'(i + 1), 1);
    checkOutput("t2_count", 32'(count),    32'd16);
    checkOutput("t2_ovf",   32'(overflow), 32'd1);
    checkOutput("t2_drops", 32'(drop_cnt), 32'd2);
    for (int i = 0; i < 16; i++) begin
      checkOutput("t2_seq", 32'(rd_seq), 32'(i));
      popOnce();
    end
    checkOutput("t2_empty", 32'(rd_valid), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, '0, '0, '0);
    checkOutput("t2_clr_ovf",   32'(overflow), 32'd0);
    checkOutput("t2_clr_drops", 32'(drop_cnt), 32'd0);

    // Push and pop together while full
    $display("[TB] full push+pop");
    doReset(1'b0);
    for (int i = 0; i < 16; i++) strobe(16'(i + 100), 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'hBEEF, 16'h1234, 16'h4321);
    checkOutput("t3_count", 32'(count),    32'd16);
    checkOutput("t3_ovf",   32'(overflow), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0);
    for (int i = 0; i < 15; i++) popOnce();
    checkOutput("t3_tail_seq", 32'(rd_seq), 32'd16);
    checkOutput("t3_tail_x",   32'(rd_x),   32'hBEEF);

    // Pop on empty, then push and pop together while empty
    $display("[TB] empty push+pop");
    doReset(1'b0);
    popOnce();
    checkOutput("t4_pop_empty", 32'(count), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0A0A, 16'h0B0B, 16'h0C0C);
    checkOutput("t4_count", 32'(count),    32'd1);
    checkOutput("t4_valid", 32'(rd_valid), 32'd1);
    checkOutput("t4_seq",   32'(rd_seq),   32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0);

    // Reset with strobe held high
    $display("[TB] reset with strobe high");
    doReset(1'b0);
    for (int i = 0; i < 4; i++) strobe(16'(i + 7), 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0055, 16'h0066, 16'h0077);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0055, 16'h0066, 16'h0077);
    checkOutput("t5_count_pre", 32'(count), 32'd5);
    doReset(1'b1);
    checkOutput("t5_count_rst", 32'(count), 32'd0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 16'h0055, 16'h0066, 16'h0077);
    checkOutput("t5_no_push", 32'(count), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0099, 16'h0088, 16'h0077);
    checkOutput("t5_repush", 32'(count),  32'd1);
    checkOutput("t5_seq",    32'(rd_seq), 32'd0);

    // 300 push/pop pairs: sequence and pointers wrap
    $display("[TB] 300 push/pop pairs");
    doReset(1'b0);
    for (int i = 0; i < 300; i++) begin
      cx = 16'($urandom); cy = 16'($urandom); cz = 16'($urandom);
      applyStimulus(1'b1, 1'b0, 1'b0, cx, cy, cz);
      applyStimulus(1'b0, 1'b1, 1'b0, cx, cy, cz);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h7777, 16'h8888, 16'h9999);
    checkOutput("t6_seq_wrap", 32'(rd_seq), 32'd44);

    // Randomized traffic with occasional clears and resets
    $display("[TB] random traffic");
    doReset(1'b0);
    drv_last = 1'b0;
    cx = '0; cy = '0; cz = '0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        sv = 1'($urandom);
        doReset(sv);
        drv_last = sv;
      end
      sv  = 1'($urandom);
      pop = (i < 750) ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 6);
      clr = ($urandom_range(0, 49) == 0);
      if (sv && !drv_last) begin
        cx = 16'($urandom); cy = 16'($urandom); cz = 16'($urandom);
      end
      drv_last = sv;
      applyStimulus(sv, pop, clr, cx, cy, cz);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/accel_sample_fifo.md
ACCEL_SAMPLE_FIFO -- requirements
Module: accel_sample_fifo

Interface
REQ-001 Parameter DEPTH, default 16, number of stored samples; power of two, 4..64.
REQ-002 Parameter DATA_W, default 16, width of each axis word.
REQ-003 clk  input  1  system clock; the 25 MHz PLL clock shared with the filter stage.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 sample_valid  input  1  new-sample strobe from the filter stage; may stay high for several cycles.
REQ-006 x_in, y_in, z_in  input  DATA_W each  filtered axis data, stable while sample_valid is high.
REQ-007 rd_pop  input  1  read side consumes the head entry.
REQ-008 clr_ovf  input  1  clears the sticky overflow flag and the drop counter.
REQ-009 rd_valid  output  1  the FIFO is non-empty and head data is valid.
REQ-010 rd_x, rd_y, rd_z  output  DATA_W each  head-entry axis data.
REQ-011 rd_seq  output  8  sequence number of the head entry.
REQ-012 count  output  $clog2(DEPTH)+1  current occupancy.
REQ-013 overflow  output  1  sticky flag; a sample has been dropped.
REQ-014 drop_cnt  output  8  dropped-sample count; saturates at 255.

Function
REQ-015 The block registers sample_valid and SHALL detect a push only on its rising edge (current 1, previous 0); one strobe yields exactly one push.
REQ-016 On a push, {x_in, y_in, z_in, seq} SHALL be written at that clock edge, where seq is an 8-bit capture counter that increments per push attempt, including dropped samples, and wraps 255->0.
REQ-017 The FIFO SHALL be first-word-fall-through: rd_valid and head data become valid in the cycle after the write edge of the first entry.
REQ-018 A pop SHALL occur when rd_pop && rd_valid; the next entry (or rd_valid=0) appears the cycle after.
REQ-019 rd_pop while empty SHALL be ignored; pointers and count are unchanged.
REQ-020 A push while full and without a pop SHALL drop the new sample, set overflow, and increment drop_cnt (saturating); stored data is unchanged.
REQ-021 A simultaneous push and pop while full SHALL accept both; count stays at DEPTH and overflow is not set.
REQ-022 A simultaneous push and pop while empty SHALL behave as a push only; the pop is ignored.
REQ-023 Otherwise, a simultaneous push and pop SHALL leave count unchanged.
REQ-024 Read and write pointers SHALL be $clog2(DEPTH) bits wide and wrap modulo DEPTH; count distinguishes full from empty.
REQ-025 clr_ovf SHALL clear overflow and drop_cnt next cycle; if it coincides with a drop, the clear wins and the drop is lost from the statistics.
REQ-026 The output data SHALL hold its value while rd_valid=0; the value is don't-care but must be X-free after reset.

Reset
REQ-027 At reset, the pointers, count, seq counter, overflow, drop_cnt, and sample_valid history register SHALL be set to 0, and rd_valid to 0.
REQ-028 Storage contents SHALL NOT be reset; the rd_x, rd_y, rd_z, and rd_seq outputs SHALL be forced to 0 while empty.
REQ-029 Reset asserted mid-operation SHALL discard all entries within one cycle; a sample_valid held high across the reset release SHALL NOT cause a push.

Structure
REQ-030 A shared package accel_pkg SHALL hold the accel_sample_t struct (x, y, z, seq), ACCEL_DATA_W=16, and ACCEL_FIFO_DEPTH=16.
REQ-031 Storage SHALL be one sub-module, accel_fifo_mem: a single write port with a combinational read port, inferable as registers or MLAB.
REQ-032 The edge detection, pointers, and flags SHALL live in the top of accel_sample_fifo; the block contains no clock-domain crossing.

Verification
REQ-033 Push 3 strobes (x=0x0010/0x0020/0x0030) each 5 cycles wide -> count=3 and seq 0,1,2; pop 3 -> data returned in order, rd_valid=0 after the third pop.
REQ-034 Fill with 16 pushes, then 2 more -> count=16, overflow=1, drop_cnt=2, head seq=0; pop all -> last seq=15; clr_ovf -> overflow=0, drop_cnt=0.
REQ-035 With the FIFO full, push and pop in the same cycle -> count stays 16, overflow=0, new tail seq=16.
REQ-036 With the FIFO empty, push and pop in the same cycle -> count=1 and rd_valid=1 next cycle; a pop on empty before that -> no change.
REQ-037 Push 5 entries, assert rst for 1 cycle with sample_valid held high, then release -> count=0, no push until sample_valid falls and rises again.
REQ-038 Run 300 push/pop pairs -> seq wraps 255->0, pointers wrap, and data matches the scoreboard throughout.
